seg_scan_driver: RTL

Time-multiplexed seven-segment display driver sitting directly downstream of the cascaded BCD digit counters. It captures the counters' concatenated BCD digits once per scan frame, decodes each digit to active-low segment patterns, and scans the common-anode digits one at a time with a programmable dwell and a guard cycle between digits. It also applies leading-zero blanking and shows a dash for non-BCD values.

---
 rtl/seg_scan_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver with snapshot, blanking and guard cycles
module seg_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [PW-1:0]           r_presc;
    logic [4*NUM_DIGITS-1:0] r_dig_snap;
    logic [NUM_DIGITS-1:0]   r_dp_snap;

    state_t                  w_state_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic [PW-1:0]           w_presc_nxt;
    logic [4*NUM_DIGITS-1:0] w_dig_nxt;
    logic [NUM_DIGITS-1:0]   w_dp_nxt;
    logic [3:0]              w_cur_dig;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_seg;
    logic                    w_dp;
    logic                    w_frame;

    // Active-low {g..a} pattern; non-BCD values show a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h3F;
        endcase
    endfunction

    // Leading zero: this digit and everything above it are zero and no dp is requested here
    function automatic logic f_blank(input logic [4*NUM_DIGITS-1:0] dig,
                                     input logic [NUM_DIGITS-1:0]   dp,
                                     input int                      k);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= k && dig[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        f_blank = (BLANK_LEADING == 1) && (k != 0) && upper_zero && !dp[k];
    endfunction

    // Next-state: outputs are registered from these so they line up with the cycle they describe
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_dig_nxt   = r_dig_snap;
        w_dp_nxt    = r_dp_snap;
        case (r_state)
            ST_IDLE: begin
                if (en_i) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                    w_dig_nxt   = digits_i;
                    w_dp_nxt    = dp_i;
                end
            end
            default: begin
                if (!en_i) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
                    w_presc_nxt = '0;
                    if (r_idx == IW'(NUM_DIGITS - 1)) begin
                        w_idx_nxt = '0;
                        w_dig_nxt = digits_i;
                        w_dp_nxt  = dp_i;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
        endcase
    end

    // Output decode for the upcoming cycle; prescaler 0 is the all-dark guard cycle
    always_comb begin
        w_cur_dig = w_dig_nxt[4*int'(w_idx_nxt) +: 4];
        w_lit     = (w_state_nxt == ST_SCAN) && (w_presc_nxt != '0)
                    && !f_blank(w_dig_nxt, w_dp_nxt, int'(w_idx_nxt));
        w_an      = '1;
        w_seg     = 7'h7F;
        w_dp      = 1'b1;
        if (w_lit) begin
            w_an[w_idx_nxt] = 1'b0;
            w_seg           = f_decode(w_cur_dig);
            w_dp            = ~w_dp_nxt[w_idx_nxt];
        end
        w_frame = (w_state_nxt == ST_SCAN) && (w_presc_nxt == PW'(REFRESH_DIV - 1))
                  && (w_idx_nxt == IW'(NUM_DIGITS - 1));
    end

    // Scan FSM state, snapshot and registered display outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_presc    <= '0;
            r_dig_snap <= '0;
            r_dp_snap  <= '0;
            an_o       <= '1;
            seg_o      <= 7'h7F;
            dp_o       <= 1'b1;
            frame_o    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_presc    <= w_presc_nxt;
            r_dig_snap <= w_dig_nxt;
            r_dp_snap  <= w_dp_nxt;
            an_o       <= w_an;
            seg_o      <= w_seg;
            dp_o       <= w_dp;
            frame_o    <= w_frame;
        end
    end

endmodule
